// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus layouts, FSM encoding and store
// byte-enable helper.
package mem_stage_pkg;

  localparam int EXE_MEM_W = 166;
  localparam int MEM_WB_W  = 125;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_HOLD      = 2'd2
  } mem_state_t;

  // EXE->MEM bus, MSB first. The struct fixes every field offset; wbytes sits at [3:0].
  typedef struct packed {
    logic        rsvd;
    logic        mem_load;
    logic        mem_store;
    logic        ls_word;
    logic        ls_dbyte;
    logic        ls_byte;
    logic        l_unsign;
    logic        ls_bytes_l;
    logic        ls_bytes_r;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        ov_ex;
    logic        ri_ex;
    logic        eret;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] pc;
    logic [3:0]  wbytes;
  } exe_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        ov_ex;
    logic        ri_ex;
    logic        eret;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] pc;
    logic [3:0]  wbytes;
  } mem_wb_t;

  function automatic logic [3:0] store_be(input logic [1:0] off,
                                          input logic is_byte,
                                          input logic is_dbyte);
    logic [3:0] be;
    if (is_byte)       be = 4'b0001 << off;
    else if (is_dbyte) be = 4'b0011 << off;
    else               be = 4'b1111;
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks/extends the addressed byte or halfword, or
// shifts the word for the unaligned LWL/LWR pair.
module mem_stage_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [3:0]  wbytes,
  input  logic        is_dbyte,
  input  logic        is_byte,
  input  logic        unsign,
  input  logic        lwl,
  input  logic        lwr,
  output logic [31:0] res
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [1:0]  n_l;
  logic [1:0]  n_r;

  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];

    // wbytes carries the merge mask from EXE; it tells how many bytes land.
    case (wbytes)
      4'b1000: n_l = 2'd0;
      4'b1100: n_l = 2'd1;
      4'b1110: n_l = 2'd2;
      default: n_l = 2'd3;
    endcase
    case (wbytes)
      4'b1111: n_r = 2'd0;
      4'b0111: n_r = 2'd1;
      4'b0011: n_r = 2'd2;
      default: n_r = 2'd3;
    endcase

    if (lwl)           res = rdata << {~n_l, 3'b000};
    else if (lwr)      res = rdata >> {n_r, 3'b000};
    else if (is_byte)  res = {{24{~unsign & b[7]}}, b};
    else if (is_dbyte) res = {{16{~unsign & h[15]}}, h};
    else               res = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-RAM accesses, aligns load data and holds
// the result for WB until it is accepted.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 MEM_go,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic                 MEM_hi_write,
  output logic                 MEM_lo_write,
  output logic [31:0]          MEM_hi_data,
  output logic [31:0]          MEM_lo_data,
  output logic                 dm_en,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata
);

  exe_mem_t    eb;
  mem_wb_t     wb;
  mem_state_t  state, state_nxt;
  logic [31:0] res_q, res_nxt, load_res, result;
  logic [1:0]  off;
  logic        unused_rsvd;

  assign eb          = exe_mem_t'(EXE_MEM_bus_r);
  assign unused_rsvd = eb.rsvd;
  assign off         = eb.exe_result[1:0];

  mem_stage_load_align load_align (
    .rdata    (dm_rdata),
    .off      (off),
    .wbytes   (eb.wbytes),
    .is_dbyte (eb.ls_dbyte),
    .is_byte  (eb.ls_byte),
    .unsign   (eb.l_unsign),
    .lwl      (eb.ls_bytes_l),
    .lwr      (eb.ls_bytes_r),
    .res      (load_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      res_q <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    res_nxt   = res_q;
    MEM_over  = 1'b0;
    dm_en     = 1'b0;
    dm_wen    = 4'b0000;
    result    = eb.exe_result;
    case (state)
      S_IDLE: begin
        if (MEM_valid) begin
          if (eb.mem_load) begin
            dm_en     = 1'b1;
            state_nxt = S_LOAD_WAIT;
          end else if (eb.mem_store) begin
            // A store is written once here; HOLD only waits for WB.
            dm_en     = 1'b1;
            dm_wen    = store_be(off, eb.ls_byte, eb.ls_dbyte);
            MEM_over  = 1'b1;
            res_nxt   = eb.exe_result;
            state_nxt = MEM_go ? S_IDLE : S_HOLD;
          end else begin
            MEM_over = 1'b1;
          end
        end
      end
      S_LOAD_WAIT: begin
        if (!MEM_valid) begin
          state_nxt = S_IDLE;
          res_nxt   = '0;
        end else begin
          result    = load_res;
          res_nxt   = load_res;
          MEM_over  = 1'b1;
          state_nxt = MEM_go ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (!MEM_valid) begin
          state_nxt = S_IDLE;
          res_nxt   = '0;
        end else begin
          result   = res_q;
          MEM_over = 1'b1;
          if (MEM_go) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      MEM_over = 1'b0;
      dm_en    = 1'b0;
      dm_wen   = 4'b0000;
    end
  end

  assign dm_addr = {eb.exe_result[31:2], 2'b00};

  always_comb begin
    if (eb.ls_byte)       dm_wdata = {4{eb.store_data[7:0]}};
    else if (eb.ls_dbyte) dm_wdata = {2{eb.store_data[15:0]}};
    else                  dm_wdata = eb.store_data;
  end

  always_comb begin
    wb.result    = result;
    wb.lo_result = eb.lo_result;
    wb.hi_write  = eb.hi_write;
    wb.lo_write  = eb.lo_write;
    wb.mfhi      = eb.mfhi;
    wb.mflo      = eb.mflo;
    wb.mtc0      = eb.mtc0;
    wb.mfc0      = eb.mfc0;
    wb.cp0r_addr = eb.cp0r_addr;
    wb.syscall   = eb.syscall;
    wb.brk       = eb.brk;
    wb.ov_ex     = eb.ov_ex;
    wb.ri_ex     = eb.ri_ex;
    wb.eret      = eb.eret;
    wb.wen       = eb.wen & ~eb.ov_ex;
    wb.wdest     = eb.wdest;
    wb.pc        = eb.pc;
    wb.wbytes    = eb.wbytes;
  end

  assign MEM_WB_bus   = wb;
  assign MEM_wdest    = MEM_valid ? eb.wdest : 5'd0;
  assign MEM_hi_write = MEM_valid & eb.hi_write;
  assign MEM_lo_write = MEM_valid & eb.lo_write;
  assign MEM_hi_data  = eb.exe_result;
  assign MEM_lo_data  = eb.lo_result;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB results are queued at issue and
// popped when the stage hands a result to WB.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                clk = 1'b0;
  logic                reset, MEM_valid, MEM_go;
  exe_mem_t            eb;
  logic                MEM_over;
  logic [MEM_WB_W-1:0] MEM_WB_bus;
  logic [4:0]          MEM_wdest;
  logic                MEM_hi_write, MEM_lo_write;
  logic [31:0]         MEM_hi_data, MEM_lo_data;
  logic                dm_en;
  logic [3:0]          dm_wen;
  logic [31:0]         dm_addr, dm_wdata, dm_rdata;
  mem_wb_t             wbo;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  wdest;
    logic        wen;
    logic [3:0]  wbytes;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0, dm_pulses = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(eb),
    .MEM_go(MEM_go), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
    .MEM_wdest(MEM_wdest), .MEM_hi_write(MEM_hi_write), .MEM_lo_write(MEM_lo_write),
    .MEM_hi_data(MEM_hi_data), .MEM_lo_data(MEM_lo_data), .dm_en(dm_en),
    .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign wbo = mem_wb_t'(MEM_WB_bus);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dm_en) dm_pulses++;
    if (MEM_over && MEM_go) begin
      if (sb.size() == 0) chk("sb_spurious", 32'(sb.size()), 1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_result", wbo.result, e.res);
        chk("wb_pc", wbo.pc, e.pc);
        chk("wb_wdest", 32'(wbo.wdest), 32'(e.wdest));
        chk("wb_wen", 32'(wbo.wen), 32'(e.wen));
        chk("wb_wbytes", 32'(wbo.wbytes), 32'(e.wbytes));
      end
    end
  end

  function automatic exe_mem_t mk(input logic ld, st, input logic [1:0] sz,
                                  input logic uns, lw_l, lw_r,
                                  input logic [31:0] addr, sd, input logic [3:0] wbytes,
                                  input logic [4:0] wd, input logic we, ov,
                                  input logic [31:0] pc);
    exe_mem_t b;
    b            = '0;
    b.mem_load   = ld;
    b.mem_store  = st;
    b.ls_word    = (sz == 2'd0);
    b.ls_dbyte   = (sz == 2'd1);
    b.ls_byte    = (sz == 2'd2);
    b.l_unsign   = uns;
    b.ls_bytes_l = lw_l;
    b.ls_bytes_r = lw_r;
    b.exe_result = addr;
    b.store_data = sd;
    b.wbytes     = wbytes;
    b.wdest      = wd;
    b.wen        = we;
    b.ov_ex      = ov;
    b.pc         = pc;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res);
    exp_t e;
    e.res    = res;
    e.pc     = eb.pc;
    e.wdest  = eb.wdest;
    e.wen    = eb.wen & ~eb.ov_ex;
    e.wbytes = eb.wbytes;
    sb.push_back(e);
  endtask

  task automatic do_store(input exe_mem_t b, input logic [3:0] be, input logic [31:0] wd,
                          input string tag);
    eb = b; MEM_valid = 1'b1; MEM_go = 1'b1;
    push(b.exe_result);
    @(negedge clk);
    chk({tag, "_en"}, 32'(dm_en), 1);
    chk({tag, "_wen"}, 32'(dm_wen), 32'(be));
    chk({tag, "_addr"}, dm_addr, {b.exe_result[31:2], 2'b00});
    chk({tag, "_wdata"}, dm_wdata, wd);
    chk({tag, "_over"}, 32'(MEM_over), 1);
    step();
    MEM_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_en"}, 32'(dm_en), 0);
    chk({tag, "_idle_over"}, 32'(MEM_over), 0);
    step();
  endtask

  task automatic do_load(input exe_mem_t b, input logic [31:0] rd, input logic [31:0] res,
                         input string tag);
    eb = b; MEM_valid = 1'b1; MEM_go = 1'b1;
    push(res);
    @(negedge clk);
    chk({tag, "_issue_en"}, 32'(dm_en), 1);
    chk({tag, "_issue_wen"}, 32'(dm_wen), 0);
    chk({tag, "_issue_over"}, 32'(MEM_over), 0);
    step();
    dm_rdata = rd;
    @(negedge clk);
    chk({tag, "_over"}, 32'(MEM_over), 1);
    chk({tag, "_wait_en"}, 32'(dm_en), 0);
    step();
    MEM_valid = 1'b0;
    dm_rdata  = $urandom;
  endtask

  initial begin
    int base;
    reset = 1'b1; MEM_valid = 1'b0; MEM_go = 1'b0; eb = '0; dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_over", 32'(MEM_over), 0);
    chk("rst_dm_en", 32'(dm_en), 0);
    chk("rst_dm_wen", 32'(dm_wen), 0);
    chk("rst_wdest", 32'(MEM_wdest), 0);
    step();
    reset = 1'b0;
    step();

    // stores: word, byte at top lane, halfword at upper half
    do_store(mk(0, 1, 0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 5'd0, 0, 0, 32'h400),
             4'b1111, 32'hDEADBEEF, "sw");
    do_store(mk(0, 1, 2, 0, 0, 0, 32'h103, 32'h000000A5, 4'b0001, 5'd0, 0, 0, 32'h404),
             4'b1000, 32'hA5A5A5A5, "sb");
    do_store(mk(0, 1, 1, 0, 0, 0, 32'h102, 32'h1234BEEF, 4'b0011, 5'd0, 0, 0, 32'h408),
             4'b1100, 32'hBEEFBEEF, "sh");

    // loads
    do_load(mk(1, 0, 2, 0, 0, 0, 32'h101, 0, 4'b1111, 5'd4, 1, 0, 32'h410),
            32'h123480FF, 32'hFFFFFF80, "lb");
    do_load(mk(1, 0, 2, 1, 0, 0, 32'h101, 0, 4'b1111, 5'd5, 1, 0, 32'h414),
            32'h123480FF, 32'h00000080, "lbu");
    do_load(mk(1, 0, 1, 0, 0, 0, 32'h102, 0, 4'b1111, 5'd6, 1, 0, 32'h418),
            32'h80011234, 32'hFFFF8001, "lh");
    do_load(mk(1, 0, 1, 1, 0, 0, 32'h200, 0, 4'b1111, 5'd7, 1, 0, 32'h41C),
            32'h1234F00D, 32'h0000F00D, "lhu");
    do_load(mk(1, 0, 0, 0, 0, 0, 32'h104, 0, 4'b1111, 5'd8, 1, 0, 32'h420),
            32'hCAFEF00D, 32'hCAFEF00D, "lw");
    do_load(mk(1, 0, 0, 0, 1, 0, 32'h201, 0, 4'b1100, 5'd9, 1, 0, 32'h424),
            32'hAABBCCDD, 32'hCCDD0000, "lwl");
    do_load(mk(1, 0, 0, 0, 0, 1, 32'h202, 0, 4'b0011, 5'd10, 1, 0, 32'h428),
            32'hAABBCCDD, 32'h0000AABB, "lwr");
    do_load(mk(1, 0, 0, 0, 1, 0, 32'h203, 0, 4'b1111, 5'd11, 1, 0, 32'h42C),
            32'h01020304, 32'h01020304, "lwl_full");
    do_load(mk(1, 0, 0, 0, 0, 1, 32'h203, 0, 4'b0001, 5'd12, 1, 0, 32'h430),
            32'hAABBCCDD, 32'h000000AA, "lwr_one");
    step();

    // non-memory op with overflow: wen suppressed, hi/lo forwarded and gated
    eb = mk(0, 0, 0, 0, 0, 0, 32'h000055AA, 0, 4'b1111, 5'd7, 1, 1, 32'h500);
    eb.hi_write = 1'b1; eb.lo_result = 32'h1111;
    MEM_valid = 1'b1; MEM_go = 1'b1;
    push(32'h000055AA);
    @(negedge clk);
    chk("nm_over", 32'(MEM_over), 1);
    chk("nm_en", 32'(dm_en), 0);
    chk("nm_hi_write", 32'(MEM_hi_write), 1);
    chk("nm_hi_data", MEM_hi_data, 32'h55AA);
    chk("nm_lo_data", MEM_lo_data, 32'h1111);
    chk("nm_wdest", 32'(MEM_wdest), 7);
    step();
    MEM_valid = 1'b0;
    @(negedge clk);
    chk("nm_gate_hi", 32'(MEM_hi_write), 0);
    chk("nm_gate_wdest", 32'(MEM_wdest), 0);
    step();

    // store stalled by WB: one RAM write, result held through HOLD
    base = dm_pulses;
    eb = mk(0, 1, 0, 0, 0, 0, 32'h300, 32'h11223344, 4'b1111, 5'd0, 0, 0, 32'h600);
    MEM_valid = 1'b1; MEM_go = 1'b0;
    push(32'h300);
    @(negedge clk);
    chk("hold_issue_en", 32'(dm_en), 1);
    chk("hold_issue_over", 32'(MEM_over), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("hold_en", 32'(dm_en), 0);
      chk("hold_over", 32'(MEM_over), 1);
    end
    step();
    MEM_go = 1'b1;
    @(negedge clk);
    chk("hold_go_over", 32'(MEM_over), 1);
    step();
    MEM_valid = 1'b0;
    step();
    chk("hold_pulses", 32'(dm_pulses - base), 1);

    // flush in LOAD_WAIT, then a fresh load must issue from IDLE
    base = dm_pulses;
    eb = mk(1, 0, 0, 0, 0, 0, 32'h700, 0, 4'b1111, 5'd3, 1, 0, 32'h700);
    MEM_valid = 1'b1; MEM_go = 1'b1;
    step();
    MEM_valid = 1'b0;
    @(negedge clk);
    chk("flush_over", 32'(MEM_over), 0);
    chk("flush_en", 32'(dm_en), 0);
    step();
    chk("flush_pulses", 32'(dm_pulses - base), 1);
    do_load(mk(1, 0, 0, 0, 0, 0, 32'h704, 0, 4'b1111, 5'd13, 1, 0, 32'h704),
            32'h5A5A0F0F, 32'h5A5A0F0F, "post_flush");
    step();

    // flush in HOLD: latched store result must not leak into the next op
    eb = mk(0, 1, 0, 0, 0, 0, 32'h800, 32'h1, 4'b1111, 5'd0, 0, 0, 32'h800);
    MEM_valid = 1'b1; MEM_go = 1'b0;
    step();
    MEM_valid = 1'b0;
    @(negedge clk);
    chk("hflush_over", 32'(MEM_over), 0);
    step();
    eb = mk(0, 0, 0, 0, 0, 0, 32'h0000BEEF, 0, 4'b1111, 5'd14, 1, 0, 32'h804);
    MEM_valid = 1'b1; MEM_go = 1'b1;
    push(32'h0000BEEF);
    @(negedge clk);
    chk("hflush_next_over", 32'(MEM_over), 1);
    step();
    MEM_valid = 1'b0;
    step();

    // reset in LOAD_WAIT
    eb = mk(1, 0, 0, 0, 0, 0, 32'h900, 0, 4'b1111, 5'd3, 1, 0, 32'h900);
    MEM_valid = 1'b1; MEM_go = 1'b1;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_lw_en", 32'(dm_en), 0);
    chk("rst_lw_over", 32'(MEM_over), 0);
    step();
    reset = 1'b0; MEM_valid = 1'b0;
    @(negedge clk);
    chk("rst_lw_after_over", 32'(MEM_over), 0);
    step();
    do_load(mk(1, 0, 2, 1, 0, 0, 32'h902, 0, 4'b1111, 5'd15, 1, 0, 32'h904),
            32'h00C30000, 32'h000000C3, "post_rst");
    step();

    // reset in HOLD
    eb = mk(0, 1, 0, 0, 0, 0, 32'hA00, 32'h2, 4'b1111, 5'd0, 0, 0, 32'hA00);
    MEM_valid = 1'b1; MEM_go = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hold_en", 32'(dm_en), 0);
    chk("rst_hold_over", 32'(MEM_over), 0);
    step();
    reset = 1'b0;
    eb = mk(0, 0, 0, 0, 0, 0, 32'h0000ABCD, 0, 4'b1111, 5'd16, 1, 0, 32'hA04);
    MEM_go = 1'b1;
    push(32'h0000ABCD);
    @(negedge clk);
    chk("rst_hold_next_over", 32'(MEM_over), 1);
    step();
    MEM_valid = 1'b0;
    step();

    chk("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
